// File: rtl/rom_port_arbiter.sv
// Shares the single cartridge ROM read port between CPU-side mapper fetches and a coprocessor fetch engine.
// Optional wait-cycle statistics are enabled by defining ROM_ARB_STATS_EN.
module rom_port_arbiter #(
  parameter int MEM_LAT    = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic        mclk,
  input  logic        rst_n,
  input  logic [23:0] rom_mask,
  input  logic        cpu_req,
  input  logic [23:0] cpu_addr,
  input  logic        cpu_word,
  output logic        cpu_ack,
  output logic [15:0] cpu_q,
  output logic        cpu_ovf,
  input  logic        cop_req,
  input  logic [23:0] cop_addr,
  input  logic        cop_word,
  output logic        cop_ack,
  output logic [15:0] cop_q,
  output logic [23:0] mem_addr,
  output logic        mem_word,
  output logic        mem_rd,
  input  logic [15:0] mem_q,
  input  logic        stat_clr,
  output logic [15:0] stat_cop_wait
);

  localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT);
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, BUSY_CPU, BUSY_COP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  lat_cnt;
  logic        cpu_pend;
  logic [23:0] pend_addr;
  logic        pend_word;
  logic [7:0]  starve_cnt;

  logic        grant_cpu, grant_cop, data_done;
  logic [23:0] sel_addr;
  logic        sel_word;
  logic [15:0] rdata;
  logic        pend_take;

  assign rdata = mem_word ? mem_q : {8'h00, mem_q[7:0]};

  // A fresh cpu_req arriving in IDLE with nothing pending is granted directly, bypassing the latch.
  always_comb begin
    state_nxt = state;
    grant_cpu = 1'b0;
    grant_cop = 1'b0;
    data_done = 1'b0;
    sel_addr  = pend_addr;
    sel_word  = pend_word;
    case (state)
      IDLE: begin
        if (cop_req && starve_cnt == STARVE_LIM) begin
          grant_cop = 1'b1;
        end else if (cpu_pend || cpu_req) begin
          grant_cpu = 1'b1;
        end else if (cop_req) begin
          grant_cop = 1'b1;
        end
        if (grant_cop) begin
          sel_addr  = cop_addr;
          sel_word  = cop_word;
          state_nxt = BUSY_COP;
        end else if (grant_cpu) begin
          state_nxt = BUSY_CPU;
          if (!cpu_pend) begin
            sel_addr = cpu_addr;
            sel_word = cpu_word;
          end
        end
      end
      BUSY_CPU, BUSY_COP: begin
        if (lat_cnt == 4'd1) begin
          data_done = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      mem_word <= 1'b0;
      cpu_ack  <= 1'b0;
      cop_ack  <= 1'b0;
      cpu_q    <= '0;
      cop_q    <= '0;
    end else begin
      state   <= state_nxt;
      mem_rd  <= grant_cpu | grant_cop;
      cpu_ack <= data_done && (state == BUSY_CPU);
      cop_ack <= data_done && (state == BUSY_COP);
      if (grant_cpu || grant_cop) begin
        lat_cnt  <= LAT_INIT;
        mem_addr <= sel_addr & rom_mask;
        mem_word <= sel_word;
      end else if (state != IDLE) begin
        lat_cnt <= lat_cnt - 4'd1;
      end
      if (data_done && state == BUSY_CPU) cpu_q <= rdata;
      if (data_done && state == BUSY_COP) cop_q <= rdata;
    end
  end

  // A pulse is latched unless it was granted directly; it is dropped only if the latch stays occupied.
  assign pend_take = cpu_req && !(grant_cpu && !cpu_pend);

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_pend  <= 1'b0;
      pend_addr <= '0;
      pend_word <= 1'b0;
      cpu_ovf   <= 1'b0;
    end else begin
      if (pend_take) begin
        if (cpu_pend && !grant_cpu) begin
          cpu_ovf <= 1'b1;
        end else begin
          cpu_pend  <= 1'b1;
          pend_addr <= cpu_addr;
          pend_word <= cpu_word;
        end
      end else if (grant_cpu) begin
        cpu_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!cop_req || grant_cop) begin
      starve_cnt <= '0;
    end else if (grant_cpu) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

`ifdef ROM_ARB_STATS_EN
  logic [15:0] wait_cnt;

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (stat_clr) begin
      wait_cnt <= '0;
    end else if (cop_req && !cop_ack && wait_cnt != 16'hFFFF) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  assign stat_cop_wait = wait_cnt;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stat_cop_wait   = 16'h0000;
`endif

endmodule
